mux_nto1_skid: RTL and testbench
================================

MUX_NTO1_SKID -- requirements
Module: mux_nto1_skid

Interface
REQ-001 Parameter WIDTH, default 16: data width per channel, in bits; legal values 1 or greater.
REQ-002 Parameter NCH, default 9: number of input channels; legal range 2 to 2^SELW.
REQ-003 Parameter SELW, default 4: select width, in bits.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_data, input, NCH*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port sel, input, SELW bits: channel select, sampled with in_data.
REQ-008 Port in_valid, input, 1 bit: the upstream beat (in_data, sel) is valid.
REQ-009 Port in_ready, output, 1 bit: the block can accept a beat; registered.
REQ-010 Port out_data, output, WIDTH bits: the selected word.
REQ-011 Port out_valid, output, 1 bit: out_data, sel_err and the beat are valid.
REQ-012 Port out_ready, input, 1 bit: downstream accepts the beat.
REQ-013 Port sel_err, output, 1 bit: the current output beat had sel >= NCH.
REQ-014 Port err_count, output, 8 bits: count of out-of-range selects (see Configuration).

Function
REQ-015 Accept occurs when in_valid && in_ready in the same cycle; the transfer is out_valid && out_ready.
REQ-016 Selection on accept: word = in_data[sel*WIDTH +: WIDTH] if sel < NCH, else all ones, with err = (sel >= NCH).
REQ-017 Storage is a 2-entry skid buffer (main and skid registers, each holding {word, err}); beats leave in strict acceptance order.
REQ-018 FSM states: EMPTY, ONE and TWO, encoding the occupancy of the buffer.
REQ-019 EMPTY transitions: accept -> ONE, with the beat loaded into main.
REQ-020 ONE transitions: accept without transfer -> TWO (beat into skid); transfer without accept -> EMPTY; accept with transfer -> ONE (main reloaded with the new beat); otherwise hold.
REQ-021 TWO transitions: transfer -> ONE (skid moves to main); otherwise hold. No accept is possible in TWO.
REQ-022 in_ready = 1 in EMPTY and ONE, and 0 in TWO; it is driven from a registered state bit, with no combinational path from out_ready.
REQ-023 out_valid = 1 in ONE and TWO; out_data and sel_err always present the main register.
REQ-024 Latency is 1 cycle from accept to out_valid when the buffer is empty.
REQ-025 Sustained throughput is 1 beat per cycle when out_ready is held high.
REQ-026 While out_valid && !out_ready, out_data and sel_err hold stable.
REQ-027 A beat is never dropped and never duplicated; in_data and sel are ignored when no accept occurs.
REQ-028 Boundary behaviour: sel = NCH-1 selects the last channel; sel = NCH up to 2^SELW-1 produces all ones with sel_err = 1.

Reset
REQ-029 While reset is high at a clock edge: state -> EMPTY, out_valid = 0, in_ready = 0, out_data = 0, sel_err = 0, err_count = 0.
REQ-030 in_ready rises to 1 on the first edge after reset deasserts.
REQ-031 Reset asserted mid-operation discards all buffered beats; reset takes priority over accept and transfer.

Configuration
REQ-032 Macro MUX_NTO1_SKID_ERRCNT_EN enables the error counter.
REQ-033 With MUX_NTO1_SKID_ERRCNT_EN defined: err_count increments by 1 on each accept with sel >= NCH, saturates at 255, and is cleared only by reset.
REQ-034 Without MUX_NTO1_SKID_ERRCNT_EN: err_count is a constant 0 and no counter flops are present; all other behaviour is identical.

Verification
REQ-035 Default parameters, out_ready = 1, 9 consecutive accepts with sel = 0..8 and channel k = 16'h1000+k -> out_data 16'h1000..16'h1008, one per cycle starting 1 cycle after the first accept, sel_err = 0 throughout.
REQ-036 sel = 9, then sel = 15, accepted -> out_data = 16'hFFFF with sel_err = 1 for both beats; with the macro defined, err_count = 2.
REQ-037 out_ready = 0, three beats offered (A, B, C) -> A and B are accepted, in_ready = 0 after the second accept, and C is held upstream; release out_ready -> outputs A, B, C in order.
REQ-038 In state ONE, accept and transfer occur in the same cycle -> state stays ONE, out_data shows the new beat next cycle, out_valid stays 1.
REQ-039 Buffer in TWO, reset pulsed for 1 cycle -> out_valid = 0 and err_count = 0; the buffered beats never appear; in_ready = 1 on the next cycle.
REQ-040 Macro defined, 300 accepts with sel = 12 -> err_count saturates at 255; without the macro, err_count = 0 throughout.

Source files
------------

// File: rtl/mux_nto1_skid.sv
// mux_nto1_skid: N-to-1 word select feeding a 2-entry skid buffer with registered in_ready.
// Optional saturating error counter enabled by MUX_NTO1_SKID_ERRCNT_EN.
`default_nettype none

module mux_nto1_skid #(
  parameter int WIDTH = 16,
  parameter int NCH   = 9,
  parameter int SELW  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]        sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sel_err,
  output logic [7:0]             err_count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             ready_q;
  logic [WIDTH-1:0] main_word;
  logic             main_err;
  logic [WIDTH-1:0] skid_word;
  logic             skid_err;
  logic [WIDTH-1:0] sel_word;
  logic             sel_bad;
  logic             accept;
  logic             transfer;

  // Out-of-range selects fall through the loop untouched: all ones, flagged.
  always_comb begin
    sel_word = '1;
    sel_bad  = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SELW'(k)) begin
        sel_word = in_data[k*WIDTH +: WIDTH];
        sel_bad  = 1'b0;
      end
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_word;
  assign sel_err   = main_err;
  assign accept    = in_valid && ready_q;
  assign transfer  = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !transfer)      state_nxt = TWO;
        else if (transfer && !accept) state_nxt = EMPTY;
      end
      TWO: if (transfer) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      ready_q   <= 1'b0;
      main_word <= '0;
      main_err  <= 1'b0;
      skid_word <= '0;
      skid_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      // Ready is a pure function of the next occupancy, so no path from out_ready.
      ready_q <= (state_nxt != TWO);
      if (accept && (state == EMPTY || (state == ONE && transfer))) begin
        main_word <= sel_word;
        main_err  <= sel_bad;
      end else if (state == TWO && transfer) begin
        main_word <= skid_word;
        main_err  <= skid_err;
      end
      if (accept && state == ONE && !transfer) begin
        skid_word <= sel_word;
        skid_err  <= sel_bad;
      end
    end
  end

`ifdef MUX_NTO1_SKID_ERRCNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= 8'd0;
    end else if (accept && sel_bad && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign err_count = err_cnt;
`else
  assign err_count = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_nto1_skid.sv
// Randomized + directed bench for mux_nto1_skid against a queue-based reference model.
`default_nettype none

module tb_mux_nto1_skid;

  localparam int WIDTH = 16;
  localparam int NCH   = 9;
  localparam int SELW  = 4;
`ifdef MUX_NTO1_SKID_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH*WIDTH-1:0] in_data;
  logic [SELW-1:0]      sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 sel_err;
  logic [7:0]           err_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [WIDTH-1:0] w;
    logic             e;
  } beat_t;

  beat_t            q[$];
  logic [WIDTH-1:0] seen[$];
  bit               exp_rdy = 1'b0;
  int               exp_cnt = 0;

  mux_nto1_skid #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the buffer is just a FIFO of at most two selected beats.
  always @(negedge clk) begin
    beat_t b;
    bit    acc;
    bit    xfer;
    check("model_out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("model_in_ready", 32'(in_ready), 32'(exp_rdy));
    check("model_err_count", 32'(err_count), 32'(exp_cnt));
    if (q.size() != 0) begin
      check("model_out_data", 32'(out_data), 32'(q[0].w));
      check("model_sel_err", 32'(sel_err), 32'(q[0].e));
    end
    if (out_valid && out_ready && !reset) seen.push_back(out_data);
    if (reset) begin
      q.delete();
      exp_rdy = 1'b0;
      exp_cnt = 0;
    end else begin
      acc  = in_valid && exp_rdy;
      xfer = (q.size() != 0) && out_ready;
      if (xfer) void'(q.pop_front());
      if (acc) begin
        b.e = (int'(sel) >= NCH);
        b.w = b.e ? {WIDTH{1'b1}} : WIDTH'(in_data >> (int'(sel) * WIDTH));
        q.push_back(b);
        if (CNT_EN && b.e && exp_cnt < 255) exp_cnt++;
      end
      exp_rdy = (q.size() < 2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_channels(input logic [WIDTH-1:0] base);
    for (int k = 0; k < NCH; k++) in_data[k*WIDTH +: WIDTH] = base + WIDTH'(k);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = '0; in_data = '0;
    tick(); tick();
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_in_ready", 32'(in_ready), 0);
    check("reset_out_data", 32'(out_data), 0);
    check("reset_sel_err", 32'(sel_err), 0);
    check("reset_err_count", 32'(err_count), 0);
    reset = 1'b0;
    tick();
    check("ready_after_reset", 32'(in_ready), 1);

    // Sweep every in-range channel at full rate.
    out_ready = 1'b1;
    fill_channels(16'h1000);
    in_valid = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      sel = SELW'(i);
      tick();
      check("sweep_data", 32'(out_data), 32'h1000 + i);
      check("sweep_err", 32'(sel_err), 0);
      check("sweep_valid", 32'(out_valid), 1);
    end

    // Out-of-range selects.
    sel = 4'd9;
    tick();
    check("oor9_data", 32'(out_data), 32'hFFFF);
    check("oor9_err", 32'(sel_err), 1);
    sel = 4'd15;
    tick();
    check("oor15_data", 32'(out_data), 32'hFFFF);
    check("oor15_err", 32'(sel_err), 1);
    in_valid = 1'b0;
    tick();
    check("oor_err_count", 32'(err_count), CNT_EN ? 2 : 0);
    tick();

    // Backpressure: A, B accepted, C held upstream, then drained in order.
    seen.delete();
    out_ready = 1'b0; in_valid = 1'b1; sel = '0;
    in_data[0 +: WIDTH] = 16'hA000; tick();
    in_data[0 +: WIDTH] = 16'hB000; tick();
    check("bp_ready_low", 32'(in_ready), 0);
    in_data[0 +: WIDTH] = 16'hC000; tick();
    check("bp_hold_data", 32'(out_data), 32'hA000);
    check("bp_hold_ready", 32'(in_ready), 0);
    out_ready = 1'b1; tick();
    check("bp_release_b", 32'(out_data), 32'hB000);
    tick();
    check("one_acc_xfer_valid", 32'(out_valid), 1);
    check("one_acc_xfer_data", 32'(out_data), 32'hC000);
    in_valid = 1'b0; tick(); tick();
    check("bp_order_len", 32'(seen.size()), 3);
    if (seen.size() == 3) begin
      check("bp_order_a", 32'(seen[0]), 32'hA000);
      check("bp_order_b", 32'(seen[1]), 32'hB000);
      check("bp_order_c", 32'(seen[2]), 32'hC000);
    end

    // Reset while full discards both beats.
    out_ready = 1'b0; in_valid = 1'b1; sel = 4'd14;
    tick(); tick();
    check("full_ready", 32'(in_ready), 0);
    seen.delete();
    reset = 1'b1; in_valid = 1'b0; tick();
    check("midreset_valid", 32'(out_valid), 0);
    check("midreset_cnt", 32'(err_count), 0);
    reset = 1'b0; out_ready = 1'b1; tick();
    check("midreset_ready", 32'(in_ready), 1);
    tick(); tick();
    check("midreset_no_beats", 32'(seen.size()), 0);

    // Counter saturation.
    in_valid = 1'b1; sel = 4'd12;
    for (int i = 0; i < 300; i++) tick();
    in_valid = 1'b0; tick();
    check("cnt_saturate", 32'(err_count), CNT_EN ? 255 : 0);

    // Random traffic with occasional reset.
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sel       = SELW'($urandom_range(0, 15));
      for (int k = 0; k < NCH; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; in_valid = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
